// File: rtl/bus_pkg.sv
// Shared bus types and constants for the two-master arbiter and its address decoder.
package bus_pkg;

  // Default bus geometry
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;

  // Number of upper address bits that pick a slave window
  localparam int unsigned WIN_W = 3;

  // Window tags carried in the top WIN_W address bits
  localparam logic [WIN_W-1:0] MEM_BASE  = 3'b000;
  localparam logic [WIN_W-1:0] DMAC_BASE = 3'b001;

  // Arbiter state: which master currently owns the bus
  typedef enum logic [0:0] {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } arb_state_e;

  // True when the address falls inside the given window
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [WIN_W-1:0]  base);
    return addr[ADDR_W-1 -: WIN_W] == base;
  endfunction

endpackage

// File: rtl/bus_addr_decoder.sv
// Combinational slave-select decoder: maps a bus address onto the memory or DMAC register window.
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int unsigned AddrW = bus_pkg::ADDR_W
) (
  input  logic [AddrW-1:0] addr_i,
  input  logic             req_i,
  output logic             s0_sel_o,
  output logic             s1_sel_o,
  output logic [AddrW-1:0] local_addr_o
);

  // Selects only fire for an active request so a parked, idle master touches nothing
  always_comb begin
    s0_sel_o = req_i && in_window(addr_i, MEM_BASE);
    s1_sel_o = req_i && in_window(addr_i, DMAC_BASE);
  end

  // Strip the window bits; slaves see a window-relative offset
  always_comb begin
    local_addr_o                     = addr_i;
    local_addr_o[AddrW-1 -: WIN_W]   = '0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (host = M0, DMAC = M1) with routing to memory (S0) and DMAC regs (S1).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = bus_pkg::ADDR_W,
  parameter int unsigned DATA_W = bus_pkg::DATA_W
) (
  input  logic              Clk,
  input  logic              reset_n,
  // Master 0: host
  input  logic              M0_req,
  input  logic              M0_wr,
  input  logic [ADDR_W-1:0] M0_address,
  input  logic [DATA_W-1:0] M0_dout,
  output logic              M0_grant,
  // Master 1: DMAC master port
  input  logic              M1_req,
  input  logic              M1_wr,
  input  logic [ADDR_W-1:0] M1_address,
  input  logic [DATA_W-1:0] M1_dout,
  output logic              M1_grant,
  // Read data back to both masters
  output logic [DATA_W-1:0] M_din,
  // Slave side
  output logic              S0_sel,
  output logic              S1_sel,
  output logic [ADDR_W-1:0] S_address,
  output logic              S_wr,
  output logic [DATA_W-1:0] S_din,
  input  logic [DATA_W-1:0] S0_dout,
  input  logic [DATA_W-1:0] S1_dout
);

  arb_state_e state_q, state_d;
  logic       m0_grant_q, m1_grant_q;

  // Next owner: the holder keeps the bus while requesting; M1 is never preempted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      GNT_M0:  if (!M0_req && M1_req) state_d = GNT_M1;
      GNT_M1:  if (!M1_req)           state_d = GNT_M0;
      default: state_d = GNT_M0;
    endcase
  end

  // State and grant registers; grants are decoded from the next state so they track state_q
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q    <= GNT_M0;
      m0_grant_q <= 1'b1;
      m1_grant_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m0_grant_q <= (state_d == GNT_M0);
      m1_grant_q <= (state_d == GNT_M1);
    end
  end

  assign M0_grant = m0_grant_q;
  assign M1_grant = m1_grant_q;

  logic              sel_req;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Forward the granted master's request, address and write data
  always_comb begin
    if (state_q == GNT_M1) begin
      sel_req   = M1_req;
      sel_wr    = M1_wr;
      sel_addr  = M1_address;
      sel_wdata = M1_dout;
    end else begin
      sel_req   = M0_req;
      sel_wr    = M0_wr;
      sel_addr  = M0_address;
      sel_wdata = M0_dout;
    end
  end

  logic              s0_sel, s1_sel;
  logic [ADDR_W-1:0] local_addr;

  bus_addr_decoder #(
    .AddrW (ADDR_W)
  ) u_decoder (
    .addr_i       (sel_addr),
    .req_i        (sel_req),
    .s0_sel_o     (s0_sel),
    .s1_sel_o     (s1_sel),
    .local_addr_o (local_addr)
  );

  // Slave-side outputs; writes outside both windows are dropped
  always_comb begin
    S0_sel    = s0_sel;
    S1_sel    = s1_sel;
    S_address = local_addr;
    S_wr      = sel_wr && (s0_sel || s1_sel);
    S_din     = sel_wdata;
  end

  // Read return: selected slave's data, zero when nothing is selected
  always_comb begin
    if (s0_sel) begin
      M_din = S0_dout;
    end else if (s1_sel) begin
      M_din = S1_dout;
    end else begin
      M_din = '0;
    end
  end

  // Exactly one master owns the bus at any time
  always_ff @(posedge Clk) begin
    if (reset_n) begin
      assert (m0_grant_q ^ m1_grant_q)
        else $error("grant not one-hot: m0=%b m1=%b", m0_grant_q, m1_grant_q);
      assert (!(s0_sel && s1_sel))
        else $error("both slave selects active");
    end
  end

endmodule
